// File: rtl/bg_frame_writer_if.sv
// rtl/bg_frame_writer_if.sv - DDR write-port bundle between the frame writer and the write arbiter
//
// Purpose: groups the burst request/acknowledge pair and the valid/ready data
// phase of one DDR write port.
// Signals:
//   wr_req   - burst request (master -> slave)
//   wr_addr  - burst start byte address, ADDR_W bits (master -> slave)
//   wr_ack   - arbiter grant (slave -> master)
//   wr_valid - data beat valid (master -> slave)
//   wr_data  - 16-bit beat data (master -> slave)
//   wr_last  - final beat of burst (master -> slave)
//   wr_ready - sink accepts beat (slave -> master)
// Modports: master (frame writer side), slave (arbiter / DDR side).

interface bg_frame_writer_if #(
   parameter int ADDR_W = 24
) ();
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_ack;
   logic              wr_valid;
   logic [15:0]       wr_data;
   logic              wr_last;
   logic              wr_ready;

   modport master (
      output wr_req, wr_addr, wr_valid, wr_data, wr_last,
      input  wr_ack, wr_ready
   );

   modport slave (
      input  wr_req, wr_addr, wr_valid, wr_data, wr_last,
      output wr_ack, wr_ready
   );
endinterface

// File: rtl/bg_frame_writer.sv
// rtl/bg_frame_writer.sv - raster-scans the background generator into DDR write bursts
//
// Purpose: on frame_start, walks the H_ACTIVE x V_ACTIVE area in raster order,
// presents x/y to the combinational background generator and streams the
// returned pixels to DDR as BURST_LEN-beat bursts (req/ack, then valid/ready).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   frame_start    - single-cycle request for one frame fill (ignored while busy)
//   h_count        - 9-bit x coordinate to the generator
//   v_count        - 9-bit y coordinate to the generator
//   bg_data        - 16-bit pixel from the generator for the current coordinate
//   busy           - frame fill in progress
//   frame_done     - single-cycle pulse after the last beat of a frame
//   wr             - DDR write port (bg_frame_writer_if.master)
// Build option: BG_FRAME_LOOP_EN - refill frames continuously after the first
// frame_start until reset.

module bg_frame_writer #(
   parameter int                H_ACTIVE  = 320,
   parameter int                V_ACTIVE  = 240,
   parameter int                BURST_LEN = 16,
   parameter int                ADDR_W    = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   output logic [8:0]        h_count,
   output logic [8:0]        v_count,
   input  logic [15:0]       bg_data,
   output logic              busy,
   output logic              frame_done,
   bg_frame_writer_if.master wr
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(2 * BURST_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BEAT_W-1:0] beat_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              xfer;
   logic              line_end;
   logic              frame_end;
   logic              burst_end;

   assign xfer      = (state == DATA) && wr.wr_ready;
   assign line_end  = (h_count == 9'(H_ACTIVE - 1));
   assign frame_end = line_end && (v_count == 9'(V_ACTIVE - 1));
   assign burst_end = (beat_cnt == BEAT_W'(BURST_LEN - 1));

   assign wr.wr_addr = addr_q;
   assign wr.wr_data = bg_data;

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      frame_done  = 1'b0;
      wr.wr_req   = 1'b0;
      wr.wr_valid = 1'b0;
      wr.wr_last  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (frame_start) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            wr.wr_req = 1'b1;
            if (wr.wr_ack) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            wr.wr_valid = 1'b1;
            wr.wr_last  = burst_end;
            // The frame always ends on a burst boundary since BURST_LEN divides
            // the pixel count; frame_end is still honoured on its own.
            if (xfer && (burst_end || frame_end)) begin
               state_nxt = frame_end ? DONE : REQ;
            end
         end
         DONE: begin
            frame_done = 1'b1;
`ifdef BG_FRAME_LOOP_EN
            state_nxt = REQ;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         h_count  <= '0;
         v_count  <= '0;
         beat_cnt <= '0;
         addr_q   <= BASE_ADDR;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  h_count <= '0;
                  v_count <= '0;
                  addr_q  <= BASE_ADDR;
               end
            end
            REQ: begin
               if (wr.wr_ack) begin
                  beat_cnt <= '0;
               end
            end
            DATA: begin
               // Coordinates only move on a transfer, so bg_data (and hence
               // wr_data) holds steady while the sink stalls.
               if (xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (line_end) begin
                     h_count <= '0;
                     v_count <= frame_end ? 9'd0 : v_count + 9'd1;
                  end else begin
                     h_count <= h_count + 9'd1;
                  end
                  if (frame_end) begin
                     addr_q <= BASE_ADDR;
                  end else if (burst_end) begin
                     addr_q <= addr_q + BURST_BYTES;
                  end
               end
            end
            DONE: begin
               h_count <= '0;
               v_count <= '0;
               addr_q  <= BASE_ADDR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bg_frame_writer.sv
// tb/tb_bg_frame_writer.sv - scoreboard bench for bg_frame_writer on a reduced 80x72 frame

module tb_bg_frame_writer;

   localparam int              H      = 80;
   localparam int              V      = 72;
   localparam int              BL     = 16;
   localparam int              AW     = 24;
   localparam logic [AW-1:0]   BASE   = 24'h10_0000;
   localparam int              NPIX   = H * V;
   localparam int              NBURST = NPIX / BL;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic [8:0]  h_count;
   logic [8:0]  v_count;
   logic [15:0] bg_data;
   logic        busy;
   logic        frame_done;

   int n_vec = 0;
   int n_err = 0;

   bg_frame_writer_if #(.ADDR_W(AW)) wr_bus ();

   bg_frame_writer #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .BURST_LEN(BL),
      .ADDR_W   (AW),
      .BASE_ADDR(BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .h_count    (h_count),
      .v_count    (v_count),
      .bg_data    (bg_data),
      .busy       (busy),
      .frame_done (frame_done),
      .wr         (wr_bus)
   );

   always #5 clk = ~clk;

   // Background generator: 64-pixel checkerboard of 0x0FFF / 0x000F, with the
   // in-tile offset XORed in so every pixel of a tile is distinct.
   function automatic logic [15:0] gen_pix(input logic [8:0] x, input logic [8:0] y);
      logic [15:0] base;
      base = (x[6] ^ y[6]) ? 16'h000F : 16'h0FFF;
      return base ^ {y[5:0], x[5:0], 4'h0};
   endfunction

   assign bg_data = gen_pix(h_count, v_count);

   task automatic stream_frame(
      input  bit            do_start,
      input  int            ack_max,
      input  int            ready_pct,
      input  int            fs_a,
      input  int            fs_b,
      output int            bursts,
      output int            beats,
      output int            dones,
      output logic [AW-1:0] first_addr,
      output logic [AW-1:0] last_addr,
      output logic [15:0]   s00,
      output logic [15:0]   s640,
      output logic [15:0]   s6464
   );
      logic [17:0]   pq[$];
      logic [AW-1:0] aq[$];
      logic [17:0]   ep;
      logic [AW-1:0] ea;
      logic [AW-1:0] held_addr;
      int            cyc;
      int            ack_wait;
      int            last_beat_cyc;
      int            done_cyc;
      bit            fin, done_seen, prev_req, in_burst, ack, rdy, fa_sent, fb_sent;
      bursts = 0; beats = 0; dones = 0;
      first_addr = '0; last_addr = '0;
      s00 = 'x; s640 = 'x; s6464 = 'x;
      fin = 0; done_seen = 0; prev_req = 0; in_burst = 0; fa_sent = 0; fb_sent = 0;
      last_beat_cyc = -10; done_cyc = -10; held_addr = '0;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            pq.push_back({9'(y), 9'(x)});
      for (int b = 0; b < NBURST; b++)
         aq.push_back(BASE + AW'(b * 2 * BL));
      wr_bus.wr_ack = 1'b0;
      wr_bus.wr_ready = 1'b0;
      if (do_start) begin
         @(negedge clk);
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
         n_vec++;
         if (wr_bus.wr_req !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_latency wr_req=%b busy=%b required 1/1", wr_bus.wr_req, busy);
         end
      end
      ack_wait = $urandom_range(0, ack_max);
      cyc = 0;
      while (!fin && cyc < 40000) begin
         if (done_seen) begin
            n_vec++;
            if (frame_done !== 1'b0 || h_count !== 9'd0 || v_count !== 9'd0) begin
               n_err++;
               $display("FAIL post_done frame_done=%b h=%0d v=%0d required 0/0/0", frame_done, h_count, v_count);
            end
            n_vec++;
`ifdef BG_FRAME_LOOP_EN
            if (busy !== 1'b1 || wr_bus.wr_req !== 1'b1) begin
               n_err++;
               $display("FAIL loop_restart busy=%b wr_req=%b required 1/1", busy, wr_bus.wr_req);
            end
`else
            if (busy !== 1'b0 || wr_bus.wr_req !== 1'b0) begin
               n_err++;
               $display("FAIL idle_after_done busy=%b wr_req=%b required 0/0", busy, wr_bus.wr_req);
            end
`endif
            fin = 1;
         end else begin
            ack = 0;
            rdy = 0;
            frame_start = 1'b0;
            n_vec++;
            if (wr_bus.wr_req === 1'b1 && wr_bus.wr_valid === 1'b1) begin
               n_err++;
               $display("FAIL req_valid_overlap at cycle %0d", cyc);
            end
            if (in_burst && wr_bus.wr_valid !== 1'b1) begin
               n_vec++;
               n_err++;
               $display("FAIL valid_dropped wr_valid=%b required 1 at beat %0d", wr_bus.wr_valid, beats);
            end
            if (wr_bus.wr_req === 1'b1) begin
               if (prev_req) begin
                  n_vec++;
                  if (wr_bus.wr_addr !== held_addr) begin
                     n_err++;
                     $display("FAIL addr_stable wr_addr=%h required %h", wr_bus.wr_addr, held_addr);
                  end
               end
               held_addr = wr_bus.wr_addr;
               if (ack_wait == 0) begin
                  ack = 1;
                  ea = (aq.size() > 0) ? aq.pop_front() : 'x;
                  n_vec++;
                  if (wr_bus.wr_addr !== ea) begin
                     n_err++;
                     $display("FAIL burst_addr burst %0d wr_addr=%h required %h", bursts, wr_bus.wr_addr, ea);
                  end
                  if (bursts == 0) first_addr = wr_bus.wr_addr;
                  last_addr = wr_bus.wr_addr;
                  bursts++;
                  ack_wait = $urandom_range(0, ack_max);
               end else begin
                  ack_wait--;
               end
            end
            if (wr_bus.wr_valid === 1'b1) begin
               rdy = ($urandom_range(0, 99) < ready_pct);
               in_burst = 1;
               if (rdy) begin
                  ep = (pq.size() > 0) ? pq.pop_front() : '1;
                  n_vec++;
                  if ({v_count, h_count} !== ep) begin
                     n_err++;
                     $display("FAIL coord beat %0d x=%0d y=%0d required x=%0d y=%0d", beats, h_count, v_count, ep[8:0], ep[17:9]);
                  end
                  n_vec++;
                  if (wr_bus.wr_data !== gen_pix(ep[8:0], ep[17:9])) begin
                     n_err++;
                     $display("FAIL data beat %0d wr_data=%h required %h", beats, wr_bus.wr_data, gen_pix(ep[8:0], ep[17:9]));
                  end
                  n_vec++;
                  if (wr_bus.wr_last !== ((beats % BL) == BL - 1)) begin
                     n_err++;
                     $display("FAIL last beat %0d wr_last=%b required %b", beats, wr_bus.wr_last, (beats % BL) == BL - 1);
                  end
                  if (ep == {9'd0, 9'd0})   s00   = wr_bus.wr_data;
                  if (ep == {9'd0, 9'd64})  s640  = wr_bus.wr_data;
                  if (ep == {9'd64, 9'd64}) s6464 = wr_bus.wr_data;
                  if (wr_bus.wr_last === 1'b1) in_burst = 0;
                  beats++;
                  if (beats == NPIX) last_beat_cyc = cyc;
               end
            end
            if (frame_done === 1'b1) begin
               dones++;
               done_seen = 1;
               done_cyc = cyc;
               n_vec++;
               if (cyc != last_beat_cyc + 1) begin
                  n_err++;
                  $display("FAIL done_timing frame_done at cycle %0d required %0d", cyc, last_beat_cyc + 1);
               end
            end
            if (fs_a >= 0 && !fa_sent && beats == fs_a) begin
               frame_start = 1'b1;
               fa_sent = 1;
            end else if (fs_b >= 0 && !fb_sent && beats == fs_b) begin
               frame_start = 1'b1;
               fb_sent = 1;
            end
            prev_req = (wr_bus.wr_req === 1'b1) && !ack;
            wr_bus.wr_ack = ack;
            wr_bus.wr_ready = rdy;
            @(negedge clk);
            cyc++;
         end
      end
      wr_bus.wr_ack = 1'b0;
      wr_bus.wr_ready = 1'b0;
      frame_start = 1'b0;
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_timeout beats=%0d required %0d within budget", beats, NPIX);
      end
      n_vec++;
      if (pq.size() != 0 || aq.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover pixels=%0d bursts=%0d required 0/0", pq.size(), aq.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frame_start     = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         wr_bus.wr_ack   = 1'($urandom_range(0, 1));
         wr_bus.wr_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_vec++;
         if ({wr_bus.wr_req, wr_bus.wr_valid, wr_bus.wr_last, busy, frame_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags req/valid/last/busy/done=%b required 00000",
                     {wr_bus.wr_req, wr_bus.wr_valid, wr_bus.wr_last, busy, frame_done});
         end
         n_vec++;
         if (h_count !== 9'd0 || v_count !== 9'd0) begin
            n_err++;
            $display("FAIL reset_coord h=%0d v=%0d required 0/0", h_count, v_count);
         end
         n_vec++;
         if (wr_bus.wr_addr !== BASE) begin
            n_err++;
            $display("FAIL reset_addr wr_addr=%h required %h", wr_bus.wr_addr, BASE);
         end
      end
      rst = 1'b0;
      frame_start = 1'b0;
      wr_bus.wr_ack = 1'b0;
      wr_bus.wr_ready = 1'b0;
      @(negedge clk);
      n_vec++;
      if (wr_bus.wr_req !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_during_reset wr_req=%b busy=%b required 0/0", wr_bus.wr_req, busy);
      end
   endtask

   task automatic test_full_frame;
      int bursts, beats, dones;
      logic [AW-1:0] fa, la;
      logic [15:0] s00, s640, s6464;
      stream_frame(1, 0, 100, -1, -1, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (bursts != NBURST || beats != NPIX) begin
         n_err++;
         $display("FAIL full_counts bursts=%0d beats=%0d required %0d/%0d", bursts, beats, NBURST, NPIX);
      end
      n_vec++;
      if (dones != 1) begin
         n_err++;
         $display("FAIL full_dones frame_done count=%0d required 1", dones);
      end
      n_vec++;
      if (fa !== BASE || la !== BASE + AW'(2 * NPIX - 2 * BL)) begin
         n_err++;
         $display("FAIL full_addr first=%h last=%h required %h/%h", fa, la, BASE, BASE + AW'(2 * NPIX - 2 * BL));
      end
      n_vec++;
      if (s00 !== 16'h0FFF || s640 !== 16'h000F || s6464 !== 16'h0FFF) begin
         n_err++;
         $display("FAIL spot_pixels (0,0)=%h (64,0)=%h (64,64)=%h required 0fff/000f/0fff", s00, s640, s6464);
      end
   endtask

   task automatic test_backpressure;
      int bursts, beats, dones;
      logic [AW-1:0] fa, la;
      logic [15:0] s00, s640, s6464;
      stream_frame(1, 7, 50, -1, -1, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (bursts != NBURST || beats != NPIX || dones != 1) begin
         n_err++;
         $display("FAIL stall_counts bursts=%0d beats=%0d dones=%0d required %0d/%0d/1", bursts, beats, dones, NBURST, NPIX);
      end
   endtask

   task automatic test_start_ignored;
      int bursts, beats, dones;
      logic [AW-1:0] fa, la;
      logic [15:0] s00, s640, s6464;
      stream_frame(1, 0, 100, 100, 5000, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (beats != NPIX || dones != 1) begin
         n_err++;
         $display("FAIL start_ignored beats=%0d dones=%0d required %0d/1", beats, dones, NPIX);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (wr_bus.wr_req !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_queued wr_req=%b frame_done=%b busy=%b required 0/0/0", wr_bus.wr_req, frame_done, busy);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int bursts, beats, dones;
      logic [AW-1:0] fa, la;
      logic [15:0] s00, s640, s6464;
      bit hit;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      beats = 0;
      hit = 0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         wr_bus.wr_ack = wr_bus.wr_req;
         wr_bus.wr_ready = 1'b1;
         if (wr_bus.wr_valid === 1'b1 && beats == 9 * BL + 7) begin
            rst = 1'b1;
            hit = 1;
         end else if (wr_bus.wr_valid === 1'b1) begin
            beats++;
         end
         @(negedge clk);
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL abort_point beats=%0d required %0d", beats, 9 * BL + 7);
      end
      n_vec++;
      if ({wr_bus.wr_req, wr_bus.wr_valid, wr_bus.wr_last, busy, frame_done} !== 5'b0) begin
         n_err++;
         $display("FAIL abort_flags req/valid/last/busy/done=%b required 00000",
                  {wr_bus.wr_req, wr_bus.wr_valid, wr_bus.wr_last, busy, frame_done});
      end
      n_vec++;
      if (h_count !== 9'd0 || v_count !== 9'd0 || wr_bus.wr_addr !== BASE) begin
         n_err++;
         $display("FAIL abort_state h=%0d v=%0d addr=%h required 0/0/%h", h_count, v_count, wr_bus.wr_addr, BASE);
      end
      rst = 1'b0;
      wr_bus.wr_ack = 1'b0;
      wr_bus.wr_ready = 1'b0;
      stream_frame(1, 0, 100, -1, -1, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (fa !== BASE || beats != NPIX || dones != 1) begin
         n_err++;
         $display("FAIL restart first_addr=%h beats=%0d dones=%0d required %h/%0d/1", fa, beats, dones, BASE, NPIX);
      end
   endtask

`ifdef BG_FRAME_LOOP_EN
   task automatic test_loop;
      int bursts, beats, dones;
      logic [AW-1:0] fa, la;
      logic [15:0] s00, s640, s6464;
      stream_frame(1, 0, 100, -1, -1, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (beats != NPIX || dones != 1) begin
         n_err++;
         $display("FAIL loop_frame1 beats=%0d dones=%0d required %0d/1", beats, dones, NPIX);
      end
      stream_frame(0, 3, 70, -1, -1, bursts, beats, dones, fa, la, s00, s640, s6464);
      n_vec++;
      if (fa !== BASE || beats != NPIX || dones != 1) begin
         n_err++;
         $display("FAIL loop_frame2 first_addr=%h beats=%0d dones=%0d required %h/%0d/1", fa, beats, dones, BASE, NPIX);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      wr_bus.wr_ack = 1'b0;
      wr_bus.wr_ready = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef BG_FRAME_LOOP_EN
      test_loop();
`else
      test_full_frame();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_burst();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
